// File: rtl/coremem_pkg.sv
// rtl/coremem_pkg.sv - shared types and constants for the two-port SRAM arbiter
package coremem_pkg;

  localparam int NUM_PORTS      = 2;
  localparam int CONFLICT_CNT_W = 16;

  typedef logic port_id_t;

  // Tag registered on every grant so the one-cycle-later SRAM response can be
  // routed back to the port that issued it.
  typedef struct packed {
    logic     valid;
    port_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/coremem_rr_arb.sv
// rtl/coremem_rr_arb.sv - 2-way request arbiter, round-robin or fixed priority
//
// Ports:
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   req          : per-port request
//   gnt          : one-hot (or zero) combinational grant
//
// Build option COREMEM_ARB_RR_EN: defined selects round-robin with a one-bit
// priority pointer; undefined selects fixed priority (port 0 wins) with no
// pointer register.
module coremem_rr_arb
  import coremem_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef COREMEM_ARB_RR_EN
  port_id_t prio_q;
  logic     conflict;

  assign conflict = &req;

  always_comb begin
    gnt = req;
    if (conflict) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  // The winner of a conflict is prio_q; it drops to lowest priority, so the
  // pointer simply flips. Non-conflict cycles leave the pointer alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (conflict) begin
      prio_q <= ~prio_q;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk_i ^ rst_i;

  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/coremem_arbiter.sv
// rtl/coremem_arbiter.sv - shares one single-port synchronous SRAM between two requesters
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/be_i [p] : core-side request per port
//   gnt_o/rvalid_o/rdata_o [p]         : combinational grant, 1-cycle response
//   sram_*                : SRAM macro pins (read data valid 1 cycle after CE)
//   conflict_cnt_o        : saturating count of cycles with both ports requesting
//
// Build option COREMEM_ARB_RR_EN selects round-robin arbitration (see
// coremem_rr_arb); undefined gives fixed priority to port 0.
module coremem_arbiter
  import coremem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic                                  sram_ce_o,
  output logic                                  sram_we_o,
  output logic [ADDR_WIDTH-1:0]                 sram_addr_o,
  output logic [DATA_WIDTH-1:0]                 sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               sram_be_o,
  input  logic [DATA_WIDTH-1:0]                 sram_rdata_i,
  output logic [CONFLICT_CNT_W-1:0]             conflict_cnt_o
);

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [NUM_PORTS-1:0] gnt;
  port_id_t             win;
  rsp_tag_t             rsp_q;

  coremem_rr_arb u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (req_i),
    .gnt   (arb_gnt)
  );

  // Grants are masked during reset so every output reads 0 while rst_i is high.
  assign gnt   = rst_i ? '0 : arb_gnt;
  assign gnt_o = gnt;
  assign win   = gnt[1];

  always_comb begin
    sram_ce_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (|gnt) begin
      sram_ce_o    = 1'b1;
      sram_we_o    = we_i[win];
      sram_addr_o  = addr_i[win];
      sram_wdata_o = wdata_i[win];
      sram_be_o    = be_i[win];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= |gnt;
      rsp_q.id    <= win;
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (rsp_q.valid) begin
      rvalid_o[rsp_q.id] = 1'b1;
      rdata_o[rsp_q.id]  = sram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if ((&req_i) && (conflict_cnt_o != {CONFLICT_CNT_W{1'b1}})) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_coremem_arbiter.sv
// tb/tb_coremem_arbiter.sv - directed self-checking bench for coremem_arbiter
module tb_coremem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req = '0;
  logic [1:0]         we = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] wdata = '0;
  logic [1:0][3:0]    be = '0;
  logic [1:0]         gnt;
  logic [1:0]         rvalid;
  logic [1:0][DW-1:0] rdata;
  logic               sram_ce;
  logic               sram_we;
  logic [AW-1:0]      sram_addr;
  logic [DW-1:0]      sram_wdata;
  logic [3:0]         sram_be;
  logic [DW-1:0]      sram_rdata = '0;
  logic [15:0]        conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  coremem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .be_i           (be),
    .gnt_o          (gnt),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .sram_ce_o      (sram_ce),
    .sram_we_o      (sram_we),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_be_o      (sram_be),
    .sram_rdata_i   (sram_rdata),
    .conflict_cnt_o (conflict_cnt)
  );

  // Single-port synchronous SRAM model, read data one cycle after CE.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    be[p]    = 4'hF;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 14'h1, 32'h0);
    set_port(1, 1'b1, 1'b0, 14'h2, 32'h0);
    settle();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (sram_ce !== 1'b0 || sram_addr !== '0) begin errors++; $display("FAIL reset_sram: ce %b addr %h want 0 0", sram_ce, sram_addr); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", conflict_cnt); end
    step();
    req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    step();
    set_port(1, 1'b1, 1'b0, 14'h0010, 32'h0);
    settle();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b want 10", gnt); end
    checks++; if (sram_ce !== 1'b1 || sram_we !== 1'b0) begin errors++; $display("FAIL rd_ce_we: got %b%b want 10", sram_ce, sram_we); end
    checks++; if (sram_addr !== 14'h0010) begin errors++; $display("FAIL rd_addr: got %h want 0010", sram_addr); end
    step();
    req = 2'b00;
    settle();
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b want 10", rvalid); end
    checks++; if (rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rdata[1]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL rd_data0: got %h want 0", rdata[0]); end
  endtask

  task automatic test_write_read;
    step();
    set_port(0, 1'b1, 1'b1, 14'h0004, 32'h12345678);
    settle();
    checks++; if (gnt !== 2'b01 || sram_we !== 1'b1) begin errors++; $display("FAIL wr_gnt: gnt %b we %b want 01 1", gnt, sram_we); end
    checks++; if (sram_wdata !== 32'h12345678 || sram_be !== 4'hF) begin errors++; $display("FAIL wr_data: got %h be %h want 12345678 f", sram_wdata, sram_be); end
    step();
    set_port(0, 1'b1, 1'b0, 14'h0004, 32'h0);
    settle();
    checks++; if (gnt !== 2'b01 || rvalid !== 2'b01) begin errors++; $display("FAIL wr_rsp: gnt %b rvalid %b want 01 01", gnt, rvalid); end
    step();
    req = 2'b00;
    settle();
    checks++; if (rvalid !== 2'b01 || rdata[0] !== 32'h12345678) begin errors++; $display("FAIL rb_data: rvalid %b data %h want 01 12345678", rvalid, rdata[0]); end
  endtask

  task automatic test_conflict;
    logic [1:0] exp_g [4];
    logic [1:0] prev;
`ifdef COREMEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    prev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      set_port(0, 1'b1, 1'b0, 14'h0100 + 14'(i), 32'h0);
      set_port(1, 1'b1, 1'b0, 14'h0200 + 14'(i), 32'h0);
      settle();
      checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL conf_gnt%0d: got %b want %b", i, gnt, exp_g[i]); end
      if (i > 0) begin
        checks++; if (rvalid !== prev) begin errors++; $display("FAIL conf_rvalid%0d: got %b want %b", i, rvalid, prev); end
      end
      prev = exp_g[i];
    end
    step();
    req = 2'b00;
    settle();
    checks++; if (rvalid !== prev) begin errors++; $display("FAIL conf_rvalid_last: got %b want %b", rvalid, prev); end
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL conf_cnt: got %0d want 4", conflict_cnt); end
  endtask

  task automatic test_mixed;
    mem[14'h0020] = 32'hA5A50F0F;
    step();
    set_port(0, 1'b1, 1'b1, 14'h0030, 32'hCAFEF00D);
    set_port(1, 1'b1, 1'b0, 14'h0020, 32'h0);
    settle();
    checks++; if (gnt !== 2'b01 || sram_we !== 1'b1) begin errors++; $display("FAIL mix_gnt: gnt %b we %b want 01 1", gnt, sram_we); end
    step();
    req[0] = 1'b0;
    settle();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL mix_rvalid0: got %b want 01", rvalid); end
    checks++; if (gnt !== 2'b10 || sram_we !== 1'b0 || sram_addr !== 14'h0020) begin errors++; $display("FAIL mix_loser: gnt %b we %b addr %h want 10 0 0020", gnt, sram_we, sram_addr); end
    step();
    req = 2'b00;
    settle();
    checks++; if (rvalid !== 2'b10 || rdata[1] !== 32'hA5A50F0F) begin errors++; $display("FAIL mix_rsp1: rvalid %b data %h want 10 a5a50f0f", rvalid, rdata[1]); end
    checks++; if (mem[14'h0030] !== 32'hCAFEF00D) begin errors++; $display("FAIL mix_wr: got %h want cafef00d", mem[14'h0030]); end
    checks++; if (conflict_cnt !== 16'd5) begin errors++; $display("FAIL mix_cnt: got %0d want 5", conflict_cnt); end
  endtask

  task automatic test_reset_inflight;
    step();
    set_port(1, 1'b1, 1'b0, 14'h0010, 32'h0);
    settle();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rst_gnt: got %b want 10", gnt); end
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00 || sram_ce !== 1'b0) begin errors++; $display("FAIL rst_mask: gnt %b ce %b want 00 0", gnt, sram_ce); end
    step();
    settle();
    checks++; if (rvalid !== 2'b00 || rdata[1] !== '0) begin errors++; $display("FAIL rst_drop: rvalid %b data %h want 00 0", rvalid, rdata[1]); end
    step();
    req = 2'b00;
    rst = 1'b0;
    settle();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_post_rvalid: got %b want 00", rvalid); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", conflict_cnt); end
    step();
    set_port(0, 1'b1, 1'b0, 14'h0001, 32'h0);
    set_port(1, 1'b1, 1'b0, 14'h0002, 32'h0);
    settle();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rst_first_conf: got %b want 01", gnt); end
  endtask

  task automatic test_saturate;
    req = 2'b11;
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h want ffff", conflict_cnt); end
    step();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    req = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h0010] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_write_read();
    test_conflict();
    test_mixed();
    test_reset_inflight();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coremem_arbiter.md
# coremem_arbiter

Two-port arbiter sharing one single-port synchronous SRAM between two requesters using the core-side req/gnt/rvalid protocol, e.g. instruction fetch (port 0) and data load/store (port 1). At most one access is granted per cycle. The granted request is driven onto the SRAM CE/WE/address/data pins, and the one-cycle-later response is routed back to the port that issued it. It sits between the core's memory ports and the SRAM macro, and replaces a per-port memory wrapper when only one SRAM instance exists.

## Interface
Parameters:
- ADDR_WIDTH, 14, SRAM word-address width
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits

Ports (p = 0, 1):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i[p]  in  1  access request
- we_i[p]  in  1  1 = write, 0 = read
- addr_i[p]  in  ADDR_WIDTH  word address
- wdata_i[p]  in  DATA_WIDTH  write data
- be_i[p]  in  DATA_WIDTH/8  byte enables
- gnt_o[p]  out  1  request accepted this cycle
- rvalid_o[p]  out  1  response valid (reads and writes)
- rdata_o[p]  out  DATA_WIDTH  read data, valid with rvalid_o
- sram_ce_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  ADDR_WIDTH  SRAM address
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after CE
- conflict_cnt_o  out  16  saturating count of cycles in which both ports requested

## Operation
- Grant is combinational in the request cycle: gnt_o[p]=1 when req_i[p]=1 and port p wins arbitration. No grant is given when neither port requests.
- Arbitration applies only when both ports request. The winner is chosen by the policy in Configuration. The loser sees gnt_o=0 and must hold its request. The loser is granted in a later cycle.
- In the grant cycle: sram_ce_o=1, sram_we_o=we_i of the winner, and addr/wdata/be are muxed from the winner. With no grant, sram_ce_o=sram_we_o=0, and addr/wdata/be are 0.
- Response tracking: a registered valid bit and port id capture each grant. In the next cycle, rvalid_o[id]=1 for exactly one cycle, for both reads and writes.
- rdata_o[id]=sram_rdata_i when rvalid_o[id]=1. Otherwise rdata_o is 0. On write responses, rdata_o is don't-care.
- Back-to-back grants are allowed, with one grant per cycle. Throughput is 1 access per cycle in aggregate.
- conflict_cnt_o increments on each cycle in which req_i[0]&req_i[1]. It saturates at 16'hFFFF with no wrap-around.
- Reset, asynchronous: the response valid bit is cleared, the id is cleared to 0, the priority pointer is set to port 0, and conflict_cnt_o is cleared to 0. Any response in flight is dropped, with no rvalid after reset. All outputs read 0 while rst_i=1.

## Timing
- Request → gnt: 0 cycles, combinational.
- gnt → rvalid: exactly 1 cycle.
- Under simultaneous requests, the loser's worst-case wait is 1 cycle with round-robin. With fixed priority it is unbounded.
- Combinational paths req_i/we_i/addr_i → gnt_o/sram_*_o are permitted. rvalid_o has no combinational path from the request inputs.

## Configuration
- Macro COREMEM_ARB_RR_EN.
- Defined: round-robin. After a conflict cycle, the last winner becomes lowest priority. The pointer updates only on cycles where both ports request. Initial priority after reset is port 0.
- Undefined: fixed priority, where port 0 always wins a conflict. The pointer register is not instantiated.
- All other behaviour is identical in both builds.

## Structure
- Package coremem_pkg holds:
  - typedef port_id_t (1 bit)
  - localparams NUM_PORTS=2 and CONFLICT_CNT_W=16
  - response-tag struct {valid, port_id_t id}
- Sub-module coremem_rr_arb: 2-way arbiter with req[1:0] in, gnt[1:0] out, and the pointer register. It takes clk_i/rst_i. The COREMEM_ARB_RR_EN selection lives inside this sub-module.
- The top level holds the muxing, the response tag register, and the conflict counter.

## Test plan
- Single read, port 1 at addr 0x0010, with the SRAM model returning 0xDEADBEEF → gnt_o[1] in the same cycle, sram_ce_o=1, sram_we_o=0; next cycle rvalid_o[1]=1, rdata_o[1]=0xDEADBEEF, rvalid_o[0]=0.
- Write then read, port 0, 0x0004 ← 0x12345678 with be=4'b1111, then a read of 0x0004 → two consecutive grants, two rvalids, read returns 0x12345678.
- Both ports request reads for 4 cycles with RR_EN defined → grants alternate 0,1,0,1. With the macro undefined → port 0 is granted every cycle and port 1 never. conflict_cnt_o=4.
- Mixed conflict, port 0 write and port 1 read in the same cycle → exactly one grant; the response is routed to the winner only; the loser is granted next cycle, and its rvalid follows one cycle after that.
- rst_i asserted in the cycle after a grant, before rvalid → no rvalid_o. After release: conflict_cnt_o=0, and the first conflict grants port 0.
- Force 65 540 conflict cycles → conflict_cnt_o holds at 0xFFFF.
